nic8_mem_arbiter: RTL
=====================

// Module: nic8_mem_arbiter
// PURPOSE
//  Shares the single-port 256x8 program/data RAM between the nic8 CPU and a program loader.
//  The loader is a debug/download port that writes or reads RAM bytes.
//  Loader access is granted only at a CPU instruction boundary. The CPU is frozen via
//  cpu_hold while the loader owns RAM. Loader bursts are bounded so the CPU cannot starve.
// PARAMETERS
//  MAX_BURST  16  max loader RAM cycles per grant (1..255); then forced release
// PORTS
//  clk         in   1  system clock, all state on posedge
//  rst_n       in   1  asynchronous, active-low reset
//  cpu_addr    in   8  CPU RAM address (abus)
//  cpu_wdata   in   8  CPU write data (dbus)
//  cpu_we      in   1  CPU store cycle (storeMem)
//  cpu_fetch   in   1  CPU is fetching next instruction this cycle (loadIR) = boundary
//  cpu_hold    out  1  freeze CPU (clock-enable low); registered
//  ldr_req     in   1  loader requests RAM ownership; level, held until done
//  ldr_gnt     out  1  loader owns RAM this cycle; registered
//  ldr_addr    in   8  loader address
//  ldr_wdata   in   8  loader write data
//  ldr_we      in   1  loader write strobe (ignored unless ldr_gnt)
//  ldr_rdata   out  8  ram_rdata passthrough when ldr_gnt, else 0
//  ram_addr    out  8  muxed RAM address
//  ram_wdata   out  8  muxed RAM write data
//  ram_we      out  1  muxed RAM write enable
//  ram_rdata   in   8  RAM read data
//  cpu_rdata   out  8  ram_rdata passthrough when !cpu_hold, else 0
// BEHAVIOUR
//  States: CPU, DRAIN, LDR, RELEASE. Reset -> CPU.
//   Reset values: cpu_hold=0, ldr_gnt=0, burst_cnt=0, owed=0.
//  CPU: cpu_hold=0, ldr_gnt=0.
//   -> DRAIN when ldr_req=1 && owed=0.
//  DRAIN: CPU keeps running.
//   ldr_req=0 -> CPU; no grant issued.
//   cpu_fetch=1 at posedge -> LDR. cpu_hold=1 and ldr_gnt=1 from that edge.
//   The fetch in the cycle before the edge completes normally.
//  LDR: ram port driven by loader; ram_we = ldr_we. burst_cnt++ each cycle.
//   -> RELEASE when ldr_req=0 or burst_cnt reaches MAX_BURST-1.
//   The cycle that reaches MAX_BURST-1 is the last granted cycle,
//   so exactly MAX_BURST loader cycles are granted.
//  RELEASE: ldr_gnt=0, cpu_hold=0, ram_we=0 for one cycle.
//   burst_cnt cleared. owed set to 1 if ldr_req still high.
//   -> CPU.
//  owed: cleared on the first cpu_fetch seen in CPU/DRAIN.
//   While owed=1, ldr_req is not honoured, so the CPU gets >=1 whole instruction per burst.
//  Mux (combinational from registered state):
//   state==LDR -> ldr_*.
//   Otherwise -> cpu_*, with ram_we = cpu_we & !cpu_hold.
//  RAM write data is never driven by both sources. No X on ram_we in any state.
//  Latency: ldr_req rise to ldr_gnt = 1 cycle + wait for next cpu_fetch edge.
//   Minimum is 2 edges.
//  Simultaneous events:
//   ldr_req falls on the same edge as cpu_fetch in DRAIN -> CPU; no grant.
//   ldr_we on the last burst cycle is honoured.
//  Reset mid-operation: async clear to CPU. Grant and hold drop immediately. Any
//   in-flight loader write is abandoned; the RAM contents for that address are unspecified.
// CONFIGURATION
//  NIC8_ARB_STATS_EN defined: adds two outputs.
//   stat_grants (8, saturating): count of LDR entries.
//   stat_stall (16, saturating): count of cycles with cpu_hold=1.
//   Both are reset to 0 by rst_n.
//  Undefined: ports and counters are absent. Arbitration behaviour is identical.
// TESTING
//  1. Reset: rst_n=0 mid-LDR -> cpu_hold=0, ldr_gnt=0 immediately.
//     Then cpu_we=1 addr 0x10 data 0x5A -> RAM[0x10]=0x5A.
//  2. Grant: ldr_req=1, cpu_fetch pulses 3 cycles later -> ldr_gnt/cpu_hold rise on that edge.
//     Loader writes 0xA5 to 0x20 -> RAM[0x20]=0xA5. A cpu_we in the same window is blocked.
//  3. Burst limit: MAX_BURST=4, ldr_req held high -> exactly 4 gnt cycles, 1 RELEASE cycle.
//     No re-grant until a cpu_fetch is seen, then re-grant on the next fetch.
//  4. Abort: ldr_req drops in DRAIN on the same edge as cpu_fetch -> ldr_gnt never asserts.
//     cpu_hold stays 0.
//  5. Readback: in LDR, ldr_addr=0x20 -> ldr_rdata=0xA5 and cpu_rdata=0.
//     After RELEASE, the CPU fetch reads the correct bytes.
//  6. With NIC8_ARB_STATS_EN: two grants of 3 cycles -> stat_grants=2, stat_stall=6.

Source files
------------

// File: rtl/nic8_mem_arbiter.sv
// nic8 RAM arbiter: shares the 256x8 RAM between the CPU and a loader, granting at fetch boundaries.
// Optional NIC8_ARB_STATS_EN adds saturating grant/stall counters.
module nic8_mem_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    input  logic       cpu_fetch,
    output logic       cpu_hold,
    input  logic       ldr_req,
    output logic       ldr_gnt,
    input  logic [7:0] ldr_addr,
    input  logic [7:0] ldr_wdata,
    input  logic       ldr_we,
    output logic [7:0] ldr_rdata,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    input  logic [7:0] ram_rdata,
    output logic [7:0] cpu_rdata
`ifdef NIC8_ARB_STATS_EN
    ,
    output logic [7:0]  stat_grants,
    output logic [15:0] stat_stall
`endif
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LDR     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t state_r;
    logic [7:0] burst_cnt_r;
    logic       owed_r;

    // Arbitration FSM with registered hold/grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CPU;
            cpu_hold    <= 1'b0;
            ldr_gnt     <= 1'b0;
            burst_cnt_r <= 8'd0;
            owed_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_CPU: begin
                    cpu_hold <= 1'b0;
                    ldr_gnt  <= 1'b0;
                    if (cpu_fetch) begin
                        owed_r <= 1'b0;
                    end
                    // owed blocks the request until the CPU has started a fresh instruction
                    if (ldr_req && !owed_r) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cpu_fetch) begin
                        owed_r <= 1'b0;
                    end
                    if (!ldr_req) begin
                        state_r <= ST_CPU;
                    end else if (cpu_fetch) begin
                        state_r     <= ST_LDR;
                        cpu_hold    <= 1'b1;
                        ldr_gnt     <= 1'b1;
                        burst_cnt_r <= 8'd0;
                    end
                end
                ST_LDR: begin
                    burst_cnt_r <= burst_cnt_r + 8'd1;
                    if (!ldr_req || (burst_cnt_r == BURST_LAST)) begin
                        state_r  <= ST_RELEASE;
                        cpu_hold <= 1'b0;
                        ldr_gnt  <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state_r     <= ST_CPU;
                    cpu_hold    <= 1'b0;
                    ldr_gnt     <= 1'b0;
                    burst_cnt_r <= 8'd0;
                    owed_r      <= ldr_req;
                end
                default: begin
                    state_r  <= ST_CPU;
                    cpu_hold <= 1'b0;
                    ldr_gnt  <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux driven only from registered state; RELEASE is a dead cycle for writes.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        case (state_r)
            ST_LDR: begin
                ram_addr  = ldr_addr;
                ram_wdata = ldr_wdata;
                ram_we    = ldr_we & ldr_gnt;
            end
            ST_RELEASE: begin
                ram_we = 1'b0;
            end
            default: begin
                ram_we = cpu_we & ~cpu_hold;
            end
        endcase
    end

    assign ldr_rdata = ldr_gnt  ? ram_rdata : 8'h00;
    assign cpu_rdata = cpu_hold ? 8'h00 : ram_rdata;

`ifdef NIC8_ARB_STATS_EN
    // Saturating counters of loader grants and CPU stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants <= 8'h00;
            stat_stall  <= 16'h0000;
        end else begin
            if ((state_r == ST_DRAIN) && ldr_req && cpu_fetch && (stat_grants != 8'hFF)) begin
                stat_grants <= stat_grants + 8'h01;
            end
            if (cpu_hold && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'h0001;
            end
        end
    end
`endif

endmodule
